// File: rtl/video_sprite_motion_ctrl.sv
// Frame-synchronous sprite motion controller: shadowed position/velocity/rate, stepped once per frame.
// Optional feature macro: VIDEO_SPRITE_MOTION_BOUNCE_EN (edge bounce mode; wrap-only when undefined).
module video_sprite_motion_ctrl #(
  parameter int SPRITE_HSIZE = 32,
  parameter int SPRITE_VSIZE = 32,
  parameter int H_DISPLAY    = 640,
  parameter int V_DISPLAY    = 480,
  parameter int VELW         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        source_vld,
  input  logic        source_frame_start,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] x0,
  output logic [31:0] y0,
  output logic [31:0] sprite_rate,
  output logic        bypass,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] frame_cnt
);

  localparam logic signed [15:0] C_HDISP = 16'(H_DISPLAY);
  localparam logic signed [15:0] C_VDISP = 16'(V_DISPLAY);
  localparam logic signed [15:0] C_XMAX  = 16'(H_DISPLAY - SPRITE_HSIZE);
  localparam logic signed [15:0] C_YMAX  = 16'(V_DISPLAY - SPRITE_VSIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_STEP_X,
    S_STEP_Y,
    S_COMMIT
  } state_t;

  typedef struct packed {
    logic signed [15:0]     pos;
    logic signed [VELW-1:0] vel;
  } step_t;

  state_t r_state, w_next;

  logic                   r_enable;
  logic                   r_bypass;
  logic                   r_overrun;
  logic [15:0]            r_x0, r_y0;
  logic [31:0]            r_rate;
  logic signed [VELW-1:0] r_dx, r_dy;
  logic signed [15:0]     r_nx, r_ny;
  logic [31:0]            r_sh_x, r_sh_y, r_sh_rate;
  logic signed [VELW-1:0] r_sh_dx, r_sh_dy;
  logic                   r_pend_x, r_pend_y, r_pend_vel;
  logic [15:0]            r_frame_cnt;

  logic                   w_fs;
  logic                   w_bounce;
  logic                   w_busy;
  logic [15:0]            w_xlim, w_ylim;
  step_t                  w_stx, w_sty;

`ifdef VIDEO_SPRITE_MOTION_BOUNCE_EN
  logic r_bounce;
  assign w_bounce = r_bounce;
`else
  assign w_bounce = 1'b0;
`endif

  assign w_fs = source_vld & source_frame_start & ~stall;

  // One axis step: zero velocity never moves or reflects, even if pos sits outside the limit.
  function automatic step_t f_step(input logic [15:0] pos, input logic signed [VELW-1:0] vel,
                                   input logic signed [15:0] disp, input logic signed [15:0] pmax,
                                   input logic bnc);
    logic signed [15:0] n;
    step_t              r;
    n     = $signed(pos) + {{(16-VELW){vel[VELW-1]}}, vel};
    r.pos = $signed(pos);
    r.vel = vel;
    if (vel != '0) begin
      r.pos = n;
      if (bnc) begin
        if (n < 0) begin
          r.pos = '0;
          r.vel = -vel;
        end else if (n > pmax) begin
          r.pos = pmax;
          r.vel = -vel;
        end
      end else begin
        if (n < 0)          r.pos = n + disp;
        else if (n >= disp) r.pos = n - disp;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] f_clamp(input logic [31:0] v, input logic [15:0] lim);
    return (v > {16'd0, lim}) ? lim : v[15:0];
  endfunction

  always_comb begin
    w_stx  = f_step(r_x0, r_dx, C_HDISP, C_XMAX, w_bounce);
    w_sty  = f_step(r_y0, r_dy, C_VDISP, C_YMAX, w_bounce);
    w_xlim = w_bounce ? C_XMAX : C_HDISP - 16'sd1;
    w_ylim = w_bounce ? C_YMAX : C_VDISP - 16'sd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      S_IDLE:   if (r_enable) w_next = S_WAIT;
      S_WAIT: begin
        if (!r_enable) w_next = S_IDLE;
        else if (w_fs) w_next = S_STEP_X;
      end
      S_STEP_X: begin
        w_busy = 1'b1;
        w_next = S_STEP_Y;
      end
      S_STEP_Y: begin
        w_busy = 1'b1;
        w_next = S_COMMIT;
      end
      S_COMMIT: begin
        w_busy = 1'b1;
        w_next = r_enable ? S_WAIT : S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable    <= 1'b0;
      r_bypass    <= 1'b1;
      r_overrun   <= 1'b0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_rate      <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_nx        <= '0;
      r_ny        <= '0;
      r_sh_x      <= '0;
      r_sh_y      <= '0;
      r_sh_rate   <= '0;
      r_sh_dx     <= '0;
      r_sh_dy     <= '0;
      r_pend_x    <= 1'b0;
      r_pend_y    <= 1'b0;
      r_pend_vel  <= 1'b0;
      r_frame_cnt <= '0;
`ifdef VIDEO_SPRITE_MOTION_BOUNCE_EN
      r_bounce    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_STEP_X: begin
          r_nx <= w_stx.pos;
          r_dx <= w_stx.vel;
        end
        S_STEP_Y: begin
          r_ny <= w_sty.pos;
          r_dy <= w_sty.vel;
        end
        S_COMMIT: begin
          r_x0        <= r_pend_x ? f_clamp(r_sh_x, w_xlim) : r_nx;
          r_y0        <= r_pend_y ? f_clamp(r_sh_y, w_ylim) : r_ny;
          r_rate      <= r_sh_rate;
          if (r_pend_vel) begin
            r_dx <= r_sh_dx;
            r_dy <= r_sh_dy;
          end
          r_pend_x    <= 1'b0;
          r_pend_y    <= 1'b0;
          r_pend_vel  <= 1'b0;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
        default: ;
      endcase

      // Placed after the commit so a write in the COMMIT cycle re-arms its pending flag.
      if (cfg_we) begin
        case (cfg_addr)
          3'd0: begin
            r_enable <= cfg_wdata[0];
`ifdef VIDEO_SPRITE_MOTION_BOUNCE_EN
            r_bounce <= cfg_wdata[1];
`endif
            r_bypass <= cfg_wdata[2];
          end
          3'd1: begin
            r_sh_x   <= cfg_wdata;
            r_pend_x <= 1'b1;
          end
          3'd2: begin
            r_sh_y   <= cfg_wdata;
            r_pend_y <= 1'b1;
          end
          3'd3: begin
            r_sh_dx    <= cfg_wdata[VELW-1:0];
            r_sh_dy    <= cfg_wdata[VELW+15:16];
            r_pend_vel <= 1'b1;
          end
          3'd4:    r_sh_rate <= cfg_wdata;
          default: ;
        endcase
      end

      if (w_fs && w_busy)
        r_overrun <= 1'b1;
      else if (cfg_we && cfg_addr == 3'd0 && cfg_wdata[3])
        r_overrun <= 1'b0;
    end
  end

  assign x0          = {16'd0, r_x0};
  assign y0          = {16'd0, r_y0};
  assign sprite_rate = r_rate;
  assign bypass      = r_bypass;
  assign busy        = w_busy;
  assign overrun     = r_overrun;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_sprite_motion_ctrl.sv
// Directed self-checking bench for video_sprite_motion_ctrl (default 640x480, 32x32 sprite).
module tb_video_sprite_motion_ctrl;

`ifdef VIDEO_SPRITE_MOTION_BOUNCE_EN
  localparam bit BNC = 1'b1;
`else
  localparam bit BNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        source_vld;
  logic        source_frame_start;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] x0, y0, sprite_rate;
  logic        bypass, busy, overrun;
  logic [15:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ex_x;

  always #5 clk = ~clk;

  video_sprite_motion_ctrl #(
    .SPRITE_HSIZE(32),
    .SPRITE_VSIZE(32),
    .H_DISPLAY(640),
    .V_DISPLAY(480),
    .VELW(8)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .source_vld(source_vld),
    .source_frame_start(source_frame_start),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .x0(x0),
    .y0(y0),
    .sprite_rate(sprite_rate),
    .bypass(bypass),
    .busy(busy),
    .overrun(overrun),
    .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick(1);
    cfg_we    = 1'b0;
  endtask

  task automatic chk_pos(input string tag, input logic [31:0] ex, input logic [31:0] ey,
                         input logic [31:0] ef);
    chk({tag, "_x0"}, x0, ex);
    chk({tag, "_y0"}, y0, ey);
    chk({tag, "_fcnt"}, {16'd0, frame_cnt}, ef);
  endtask

  // slot 1/2/3 = STEP_X/STEP_Y/COMMIT cycle for an extra cfg write and/or frame start.
  task automatic run_frame(input int slot, input logic wr, input logic [2:0] a,
                           input logic [31:0] d, input logic fs2,
                           input logic [31:0] x_prev, input logic [31:0] y_prev);
    source_vld         = 1'b1;
    source_frame_start = 1'b1;
    tick(1);
    source_vld         = 1'b0;
    source_frame_start = 1'b0;
    chk("busy_step", {31'd0, busy}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      if (c == slot) begin
        if (wr) begin
          cfg_we    = 1'b1;
          cfg_addr  = a;
          cfg_wdata = d;
        end
        if (fs2) begin
          source_vld         = 1'b1;
          source_frame_start = 1'b1;
        end
      end
      tick(1);
      cfg_we             = 1'b0;
      source_vld         = 1'b0;
      source_frame_start = 1'b0;
      if (c == 2) begin
        chk("x0_hold", x0, x_prev);
        chk("y0_hold", y0, y_prev);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; source_vld = 1'b0; source_frame_start = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    tick(3);
    chk_pos("rst", 0, 0, 0);
    chk("rst_rate", sprite_rate, 0);
    chk("rst_bypass", {31'd0, bypass}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ovr", {31'd0, overrun}, 0);
    rst_n = 1'b1;
    tick(1);

    // Wrap: X 630, dx +20, dy -5
    cfg_wr(3'd1, 32'd630);
    cfg_wr(3'd2, 32'd0);
    cfg_wr(3'd3, 32'h00FB_0014);
    cfg_wr(3'd4, 32'd4);
    cfg_wr(3'd0, 32'd1);
    tick(1);
    chk("bypass_off", {31'd0, bypass}, 0);
    run_frame(0, 1'b0, 3'd0, 0, 1'b0, 0, 0);
    chk_pos("wrap1", 630, 0, 1);
    chk("rate", sprite_rate, 4);
    run_frame(0, 1'b0, 3'd0, 0, 1'b0, 630, 0);
    chk_pos("wrap2", 10, 475, 2);
    run_frame(0, 1'b0, 3'd0, 0, 1'b0, 10, 475);
    chk_pos("wrap3", 30, 470, 3);

    // VEL written in COMMIT takes effect only after the following commit
    run_frame(3, 1'b1, 3'd3, 32'h0001_0001, 1'b0, 30, 470);
    chk_pos("shad1", 50, 465, 4);
    run_frame(0, 1'b0, 3'd0, 0, 1'b0, 50, 465);
    chk_pos("shad2", 70, 460, 5);
    run_frame(0, 1'b0, 3'd0, 0, 1'b0, 70, 460);
    chk_pos("shad3", 71, 461, 6);

    // Overrun: extra frame start during STEP_Y
    run_frame(2, 1'b0, 3'd0, 0, 1'b1, 71, 461);
    chk_pos("ovr", 72, 462, 7);
    chk("ovr_set", {31'd0, overrun}, 1);
    tick(3);
    chk_pos("ovr_idle", 72, 462, 7);
    chk("ovr_busy", {31'd0, busy}, 0);

    // Stalled frame start is not sampled
    stall = 1'b1; source_vld = 1'b1; source_frame_start = 1'b1;
    tick(2);
    chk("stall_busy", {31'd0, busy}, 0);
    stall = 1'b0; source_vld = 1'b0; source_frame_start = 1'b0;
    tick(4);
    chk_pos("stall", 72, 462, 7);

    cfg_wr(3'd0, 32'd9);
    chk("ovr_clr", {31'd0, overrun}, 0);

    // Set beats clear when fs overrun and clr_ovr coincide
    run_frame(1, 1'b1, 3'd0, 32'd9, 1'b1, 72, 462);
    chk_pos("ovr2", 73, 463, 8);
    chk("ovr_setwins", {31'd0, overrun}, 1);
    cfg_wr(3'd0, 32'd9);
    chk("ovr_clr2", {31'd0, overrun}, 0);

    // Bounce request (ignored without the bounce build), dx +10, dy 0
    cfg_wr(3'd0, 32'd3);
    cfg_wr(3'd1, 32'd600);
    cfg_wr(3'd2, 32'd100);
    cfg_wr(3'd3, 32'h0000_000A);
    run_frame(0, 1'b0, 3'd0, 0, 1'b0, 73, 463);
    chk_pos("bnc1", 600, 100, 9);
    ex_x = BNC ? 32'd608 : 32'd610;
    run_frame(0, 1'b0, 3'd0, 0, 1'b0, 600, 100);
    chk_pos("bnc2", ex_x, 100, 10);
    run_frame(0, 1'b0, 3'd0, 0, 1'b0, ex_x, 100);
    ex_x = BNC ? 32'd598 : 32'd620;
    chk_pos("bnc3", ex_x, 100, 11);

    // Out-of-range X_INIT clamps to H_DISPLAY-1 in wrap mode
    cfg_wr(3'd0, 32'd1);
    cfg_wr(3'd1, 32'd1000);
    run_frame(0, 1'b0, 3'd0, 0, 1'b0, ex_x, 100);
    chk_pos("clamp", 639, 100, 12);

    // Disable during STEP_X: commit still happens, then IDLE
    run_frame(1, 1'b1, 3'd0, 32'd0, 1'b0, 639, 100);
    ex_x = BNC ? 32'd629 : 32'd9;
    chk_pos("dis", ex_x, 100, 13);
    tick(1);
    chk("dis_busy", {31'd0, busy}, 0);
    source_vld = 1'b1; source_frame_start = 1'b1;
    tick(1);
    source_vld = 1'b0; source_frame_start = 1'b0;
    tick(5);
    chk_pos("dis_idle", ex_x, 100, 13);
    chk("dis_busy2", {31'd0, busy}, 0);

    // Reset in the middle of a sequence
    cfg_wr(3'd0, 32'd1);
    tick(1);
    source_vld = 1'b1; source_frame_start = 1'b1;
    tick(1);
    source_vld = 1'b0; source_frame_start = 1'b0;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk_pos("mrst", 0, 0, 0);
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_bypass", {31'd0, bypass}, 1);
    chk("mrst_rate", sprite_rate, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
